fir_tap_loader: RTL and testbench
=================================

FIR_TAP_LOADER -- requirements
Module: fir_tap_loader

Interface
REQ-001 Parameter n, default 10, number of filter taps; n >= 2.
REQ-002 Parameter w, default 16, tap word width in bits.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cfg_data  input  w  coefficient word, unsigned Q1.15 as consumed by fir.
REQ-006 cfg_valid  input  1  cfg_data/cfg_last valid this cycle.
REQ-007 cfg_last  input  1  marks final word of a coefficient frame.
REQ-008 cfg_ready  output  1  loader can accept a word this cycle.
REQ-009 commit  input  1  single-cycle request to publish the shadow bank.
REQ-010 err_clear  input  1  clears sticky error flags.
REQ-011 taps  output  n x w (unpacked [n-1:0])  active coefficient bank; connects directly to fir taps.
REQ-012 taps_valid  output  1  at least one bank committed since reset.
REQ-013 taps_updated  output  1  one-cycle pulse, cycle after taps change.
REQ-014 busy  output  1  state is not IDLE.
REQ-015 err_short  output  1  sticky: frame ended before n words.
REQ-016 err_long  output  1  sticky: frame exceeded n words.

Function
REQ-017 Transfer occurs on a rising edge where cfg_valid && cfg_ready; no other edge consumes a word.
REQ-018 The loader SHALL hold a shadow bank of n words plus a word index 0..n-1; active taps change only on commit.
REQ-019 Word k of a frame (k = 0 first) SHALL be written to shadow[k], which maps to taps[k].
REQ-020 States: IDLE, LOAD, FULL, DRAIN; cfg_ready = 1 in IDLE, LOAD, DRAIN; 0 in FULL; combinational from state.
REQ-021 IDLE: transfer writes shadow[0], index <= 1, -> LOAD; if cfg_last on that word -> err_short set, -> IDLE.
REQ-022 LOAD, index < n-1: transfer writes shadow[index], index++; if cfg_last -> err_short set, shadow discarded, -> IDLE.
REQ-023 LOAD, index = n-1: transfer writes shadow[n-1]; cfg_last=1 -> FULL; cfg_last=0 -> err_long set, -> DRAIN.
REQ-024 DRAIN: accepts and discards words; transfer with cfg_last -> IDLE; shadow never published.
REQ-025 FULL: commit sampled high -> taps <= shadow on that edge, taps_valid <= 1, -> IDLE; taps_updated high the following cycle only.
REQ-026 commit in IDLE, LOAD or DRAIN SHALL be ignored, with no effect on taps or flags.
REQ-027 Latency: commit edge -> new taps visible next cycle; last word edge -> FULL next cycle, earliest commit accepted in that cycle.
REQ-028 Active taps SHALL stay stable during LOAD/DRAIN/FULL; an aborted frame leaves prior taps intact.
REQ-029 err_clear clears both error flags; a new error setting on the same edge wins (flag ends set).
REQ-030 Data words are stored bit-exact; no arithmetic, saturation or sign handling.

Reset
REQ-031 Reset SHALL force state IDLE, index 0, shadow and taps all 0, taps_valid 0, taps_updated 0, err_short 0, err_long 0.
REQ-032 Reset asserted mid-frame or in FULL SHALL abandon the frame; no commit occurs on the reset edge even if commit is high.
REQ-033 cfg_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 n=10: send words 1..10 (last on 10), commit -> next cycle taps[0..9]=1..10, taps_valid=1, taps_updated one cycle.
REQ-035 Load 10 words 0x4000 with cfg_valid toggling every other cycle, hold commit low 5 cycles -> cfg_ready=0 throughout FULL, taps unchanged until commit.
REQ-036 Send 4 words with cfg_last on word 4 -> err_short=1, busy=0, previous taps unchanged; err_clear -> err_short=0.
REQ-037 Send 12 words, cfg_last on word 12 -> err_long=1, words 11-12 accepted and discarded, state IDLE, taps unchanged; commit ignored.
REQ-038 Reset asserted after word 6 -> all outputs 0; next full 10-word frame of 0x7FFF plus commit -> taps all 0x7FFF.
REQ-039 Drive taps into fir with impulse xin=0x7FFF then 0 -> fir output sequence follows the committed coefficients scaled by 0x7FFF/2^15.

Source files
------------

// File: rtl/fir_tap_loader_if.sv
// Coefficient configuration stream between a tap source and fir_tap_loader.
interface fir_tap_loader_if #(
   parameter int unsigned w = 16
);

   logic [w-1:0] cfg_data;
   logic         cfg_valid;
   logic         cfg_last;
   logic         cfg_ready;

   // Source side drives words, loader answers with ready.
   modport master (
      output cfg_data,
      output cfg_valid,
      output cfg_last,
      input  cfg_ready
   );

   // Loader side.
   modport slave (
      input  cfg_data,
      input  cfg_valid,
      input  cfg_last,
      output cfg_ready
   );

endinterface

// File: rtl/fir_tap_loader.sv
// Double-buffered FIR coefficient loader: words stream into a shadow bank and
// are published to the active taps only on a commit after a complete frame.
// Frames shorter or longer than n words are flagged and never published.
// n must be at least 2.
module fir_tap_loader #(
   parameter int unsigned n = 10,
   parameter int unsigned w = 16
) (
   input  logic                clock,
   input  logic                reset,
   fir_tap_loader_if.slave     cfg,
   input  logic                commit,
   input  logic                err_clear,
   output logic [w-1:0]        taps [n-1:0],
   output logic                taps_valid,
   output logic                taps_updated,
   output logic                busy,
   output logic                err_short,
   output logic                err_long
);

   localparam int unsigned iw = (n > 1) ? $clog2(n) : 1;
   localparam logic [iw-1:0] last_idx = iw'(n - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FULL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t        state;
   logic [iw-1:0] index;
   logic [w-1:0]  shadow [n-1:0];
   logic          xfer;

   // Ready depends only on state so the source sees it before the edge.
   assign cfg.cfg_ready = (state != FULL);
   assign busy          = (state != IDLE);
   assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

   // Frame sequencing, shadow capture, publish on commit and sticky errors.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         index        <= '0;
         taps_valid   <= 1'b0;
         taps_updated <= 1'b0;
         err_short    <= 1'b0;
         err_long     <= 1'b0;
         for (int i = 0; i < int'(n); i++) begin
            shadow[i] <= '0;
            taps[i]   <= '0;
         end
      end else begin
         taps_updated <= 1'b0;

         // Clear first so that an error detected on this edge overrides it.
         if (err_clear) begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (xfer) begin
                  shadow[0] <= cfg.cfg_data;
                  if (cfg.cfg_last) begin
                     err_short <= 1'b1;
                     index     <= '0;
                  end else begin
                     index <= iw'(1);
                     state <= LOAD;
                  end
               end
            end

            LOAD: begin
               if (xfer) begin
                  shadow[index] <= cfg.cfg_data;
                  if (index == last_idx) begin
                     index <= '0;
                     if (cfg.cfg_last) begin
                        state <= FULL;
                     end else begin
                        err_long <= 1'b1;
                        state    <= DRAIN;
                     end
                  end else if (cfg.cfg_last) begin
                     err_short <= 1'b1;
                     index     <= '0;
                     state     <= IDLE;
                  end else begin
                     index <= index + iw'(1);
                  end
               end
            end

            FULL: begin
               if (commit) begin
                  taps         <= shadow;
                  taps_valid   <= 1'b1;
                  taps_updated <= 1'b1;
                  state        <= IDLE;
               end
            end

            DRAIN: begin
               if (xfer && cfg.cfg_last) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
               index <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_loader.sv
// Bench for fir_tap_loader: directed scenarios with literal expectations plus a
// randomized frame stream, all checked every cycle against a frame-level model.
module tb_fir_tap_loader;

   localparam int unsigned n = 10;
   localparam int unsigned w = 16;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         commit = 1'b0;
   logic         err_clear = 1'b0;
   logic [w-1:0] taps [n-1:0];
   logic         taps_valid;
   logic         taps_updated;
   logic         busy;
   logic         err_short;
   logic         err_long;

   int errors = 0;
   int checks = 0;
   bit rnd_ctl = 1'b0;

   fir_tap_loader_if #(.w(w)) cfg ();

   fir_tap_loader #(.n(n), .w(w)) dut (
      .clock        (clock),
      .reset        (reset),
      .cfg          (cfg.slave),
      .commit       (commit),
      .err_clear    (err_clear),
      .taps         (taps),
      .taps_valid   (taps_valid),
      .taps_updated (taps_updated),
      .busy         (busy),
      .err_short    (err_short),
      .err_long     (err_long)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: words collected per frame, judged by count at the last word.
   logic [w-1:0] m_taps  [n-1:0];
   logic [w-1:0] m_frame [n-1:0];
   int  m_count = 0;
   bit  m_full = 0, m_valid = 0, m_upd = 0, m_short = 0, m_long = 0;

   always @(posedge clock) begin
      if (reset) begin
         m_count = 0; m_full = 0; m_valid = 0; m_upd = 0; m_short = 0; m_long = 0;
         for (int i = 0; i < int'(n); i++) m_taps[i] = '0;
      end else begin
         bit rdy;
         rdy   = !m_full;
         m_upd = 0;
         if (err_clear) begin
            m_short = 0;
            m_long  = 0;
         end
         if (m_full && commit) begin
            m_taps  = m_frame;
            m_valid = 1;
            m_upd   = 1;
            m_full  = 0;
         end else if (cfg.cfg_valid && rdy) begin
            if (m_count < int'(n)) m_frame[m_count] = cfg.cfg_data;
            m_count++;
            if (cfg.cfg_last) begin
               if (m_count < int'(n)) m_short = 1;
               else if (m_count == int'(n)) m_full = 1;
               m_count = 0;
            end else if (m_count == int'(n)) begin
               m_long = 1;
            end
         end
      end
   end

   // Every cycle, compare DUT outputs with the model away from the active edge.
   always @(negedge clock) begin
      chk("cfg_ready", cfg.cfg_ready, !m_full);
      chk("busy", busy, (m_count > 0) || m_full);
      chk("taps_valid", taps_valid, m_valid);
      chk("taps_updated", taps_updated, m_upd);
      chk("err_short", err_short, m_short);
      chk("err_long", err_long, m_long);
      for (int i = 0; i < int'(n); i++) chk($sformatf("taps[%0d]", i), taps[i], m_taps[i]);
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rnd_ctl) begin
         commit    = ($urandom % 10) == 0;
         err_clear = ($urandom % 12) == 0;
      end
   endtask

   // One transfer; waits (bounded) for ready before the transferring edge.
   task automatic send(input logic [w-1:0] d, input bit last);
      int budget;
      budget = 40;
      cfg.cfg_data  = d;
      cfg.cfg_last  = last;
      cfg.cfg_valid = 1'b1;
      while (!cfg.cfg_ready && budget > 0) begin
         tick();
         budget--;
      end
      checks++;
      if (budget == 0) begin
         errors++;
         $display("FAIL send_timeout: cfg_ready stayed 0 for 40 cycles at %0t", $time);
      end
      tick();
      cfg.cfg_valid = 1'b0;
      cfg.cfg_last  = 1'b0;
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic do_commit();
      commit = 1'b1;
      @(posedge clock);
      #1;
      commit = 1'b0;
   endtask

   initial begin
      cfg.cfg_data  = '0;
      cfg.cfg_valid = 1'b0;
      cfg.cfg_last  = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;

      // Reset state.
      chk("rst_cfg_ready", cfg.cfg_ready, 1'b1);
      chk("rst_taps_valid", taps_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_tap0", taps[0], 16'h0000);

      // Words 1..n then commit.
      for (int k = 1; k <= int'(n); k++) send(w'(k), k == int'(n));
      chk("full_ready", cfg.cfg_ready, 1'b0);
      do_commit();
      for (int k = 0; k < int'(n); k++) chk("seq_tap", taps[k], 64'(k + 1));
      chk("seq_valid", taps_valid, 1'b1);
      chk("seq_upd", taps_updated, 1'b1);
      tick();
      chk("seq_upd_drop", taps_updated, 1'b0);

      // Gapped 0x4000 frame, commit held off for 5 cycles.
      for (int k = 0; k < int'(n); k++) begin
         send(16'h4000, k == int'(n) - 1);
         if (k != int'(n) - 1) tick();
      end
      for (int c = 0; c < 5; c++) begin
         chk("hold_ready", cfg.cfg_ready, 1'b0);
         chk("hold_tap9", taps[n-1], 16'd10);
         tick();
      end
      do_commit();
      for (int k = 0; k < int'(n); k++) chk("q_tap", taps[k], 16'h4000);

      // Short frame.
      for (int k = 1; k <= 4; k++) send(16'h1234, k == 4);
      chk("short_err", err_short, 1'b1);
      chk("short_busy", busy, 1'b0);
      chk("short_tap", taps[3], 16'h4000);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("short_clear", err_short, 1'b0);

      // Long frame, then ignored commit.
      for (int k = 1; k <= 12; k++) send(16'h5555, k == 12);
      chk("long_err", err_long, 1'b1);
      chk("long_busy", busy, 1'b0);
      do_commit();
      chk("long_upd", taps_updated, 1'b0);
      chk("long_tap", taps[0], 16'h4000);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;

      // Reset mid-frame with commit high.
      for (int k = 1; k <= 6; k++) send(16'h2222, 1'b0);
      commit = 1'b1;
      reset  = 1'b1;
      idle(2);
      reset  = 1'b0;
      commit = 1'b0;
      chk("mrst_tap", taps[0], 16'h0000);
      chk("mrst_valid", taps_valid, 1'b0);
      chk("mrst_busy", busy, 1'b0);
      chk("mrst_ready", cfg.cfg_ready, 1'b1);
      for (int k = 1; k <= int'(n); k++) send(16'h7FFF, k == int'(n));
      do_commit();
      // Impulse of 0x7FFF through Q1.15 taps of 0x7FFF gives 0x7FFE per output.
      for (int k = 0; k < int'(n); k++) begin
         logic [31:0] prod;
         prod = 32'(taps[k]) * 32'h7FFF;
         chk("fir_impulse", 64'(prod >> 15), 16'h7FFE);
      end

      // Randomized frames with random commit/err_clear pulses and occasional reset.
      rnd_ctl = 1'b1;
      for (int it = 0; it < 250; it++) begin
         int len;
         len = ($urandom % 2 == 0) ? int'(n) : int'($urandom_range(1, n + 3));
         for (int k = 1; k <= len; k++) begin
            if ($urandom % 3 == 0) tick();
            send(w'($urandom), k == len);
         end
         idle(int'($urandom_range(0, 3)));
         do_commit();
         if ($urandom % 25 == 0) begin
            reset = 1'b1;
            idle(2);
            reset = 1'b0;
         end
      end
      rnd_ctl   = 1'b0;
      commit    = 1'b0;
      err_clear = 1'b0;
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
